// File: rtl/pll_reset_sequencer.sv
// PLL bring-up and CPU reset sequencer running on the free-running reference clock.
// Optional WAIT_LOCK timeout compiled in with macro PLL_SEQ_TIMEOUT_EN.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// PLL_RST   | pll_rst held high for PLL_RST_CYCLES, CPU held in reset
// WAIT_LOCK | PLL released, waiting for synchronised lock
// STABLE    | lock seen, counting LOCK_STABLE_CYCLES of uninterrupted lock
// RUN       | CPU released, ready high, any lock loss restarts the PLL
module pll_reset_sequencer #(
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int LOCK_TIMEOUT_CYCLES = 50000
) (
    input  logic       refclk,
    input  logic       rst_n,
    input  logic       locked,
    output logic       pll_rst,
    output logic       cpu_rst_n,
    output logic       ready,
    output logic [7:0] loss_count
);

    typedef enum logic [1:0] {
        PLL_RST   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [15:0] RST_LAST    = 16'(PLL_RST_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST = 16'(LOCK_STABLE_CYCLES - 1);
`ifdef PLL_SEQ_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
`endif

    // Elaboration-time guard: every count must fit the 16-bit counter.
    if (PLL_RST_CYCLES < 1 || PLL_RST_CYCLES > 65535) begin : g_bad_pll_rst_cycles
        $error("PLL_RST_CYCLES out of range");
    end
    if (LOCK_STABLE_CYCLES < 1 || LOCK_STABLE_CYCLES > 65535) begin : g_bad_lock_stable_cycles
        $error("LOCK_STABLE_CYCLES out of range");
    end
    if (LOCK_TIMEOUT_CYCLES < 1 || LOCK_TIMEOUT_CYCLES > 65535) begin : g_bad_lock_timeout_cycles
        $error("LOCK_TIMEOUT_CYCLES out of range");
    end

    state_t      state, state_nxt;
    logic [15:0] cnt, cnt_nxt;
    logic [7:0]  loss_count_nxt;
    logic        lock_meta, lock_s;
    logic        pll_rst_nxt, cpu_rst_n_nxt, ready_nxt;

    always_ff @(posedge refclk) begin
        if (!rst_n) begin
            lock_meta  <= 1'b0;
            lock_s     <= 1'b0;
            state      <= PLL_RST;
            cnt        <= '0;
            loss_count <= '0;
            pll_rst    <= 1'b1;
            cpu_rst_n  <= 1'b0;
            ready      <= 1'b0;
        end else begin
            lock_meta  <= locked;
            lock_s     <= lock_meta;
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            loss_count <= loss_count_nxt;
            pll_rst    <= pll_rst_nxt;
            cpu_rst_n  <= cpu_rst_n_nxt;
            ready      <= ready_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt + 16'd1;
        loss_count_nxt = loss_count;
        case (state)
            PLL_RST: begin
                if (cnt == RST_LAST) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end
            end
            WAIT_LOCK: begin
                if (lock_s) begin
                    state_nxt = STABLE;
                    cnt_nxt   = '0;
                end
`ifdef PLL_SEQ_TIMEOUT_EN
                else if (cnt == TIMEOUT_LAST) begin
                    state_nxt = PLL_RST;
                    cnt_nxt   = '0;
                end
`else
                else begin
                    cnt_nxt = '0;
                end
`endif
            end
            STABLE: begin
                if (!lock_s) begin
                    state_nxt = WAIT_LOCK;
                    cnt_nxt   = '0;
                end else if (cnt == STABLE_LAST) begin
                    state_nxt = RUN;
                    cnt_nxt   = '0;
                end
            end
            RUN: begin
                // RUN has no count-based exit, so the counter is parked at zero.
                cnt_nxt = '0;
                if (!lock_s) begin
                    state_nxt = PLL_RST;
                    if (loss_count != 8'hFF) begin
                        loss_count_nxt = loss_count + 8'd1;
                    end
                end
            end
            default: begin
                state_nxt = PLL_RST;
                cnt_nxt   = '0;
            end
        endcase

        pll_rst_nxt   = (state_nxt == PLL_RST);
        cpu_rst_n_nxt = (state_nxt == RUN);
        ready_nxt     = (state_nxt == RUN);
    end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer with PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8,
// LOCK_TIMEOUT_CYCLES=32; expectations follow PLL_SEQ_TIMEOUT_EN when it is defined.
module tb_pll_reset_sequencer;

    localparam int P_RST = 4;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       locked;
    logic       pll_rst;
    logic       cpu_rst_n;
    logic       ready;
    logic [7:0] loss_count;

    int checks   = 0;
    int failures = 0;
    int exp_loss;

    pll_reset_sequencer #(
        .PLL_RST_CYCLES      (P_RST),
        .LOCK_STABLE_CYCLES  (P_STB),
        .LOCK_TIMEOUT_CYCLES (P_TO)
    ) dut (
        .refclk     (refclk),
        .rst_n      (rst_n),
        .locked     (locked),
        .pll_rst    (pll_rst),
        .cpu_rst_n  (cpu_rst_n),
        .ready      (ready),
        .loss_count (loss_count)
    );

    always #5 refclk = ~refclk;

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        locked = 1'b0;
        step(3);
        check("reset_pll_rst", {7'd0, pll_rst}, 8'd1);
        check("reset_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        check("reset_ready", {7'd0, ready}, 8'd0);
        check("reset_loss_count", loss_count, 8'd0);

        // Bring-up: pll_rst high through the 4-cycle pulse, then lock arrives.
        rst_n = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            check("bringup_pll_rst", {7'd0, pll_rst}, {7'd0, (k < 4)});
        end
        locked = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check("bringup_cpu_rst_n", {7'd0, cpu_rst_n}, {7'd0, (k >= 11)});
            check("bringup_ready", {7'd0, ready}, {7'd0, (k >= 11)});
            check("bringup_pll_rst_low", {7'd0, pll_rst}, 8'd0);
        end
        check("bringup_loss_count", loss_count, 8'd0);

        // One-cycle lock glitch at stable count 5 restarts the full count.
        rst_n  = 1'b0;
        locked = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(6);
        locked = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            step(1);
            check("glitch_cpu_rst_n", {7'd0, cpu_rst_n}, {7'd0, (k >= 18)});
            if (k == 6) locked = 1'b0;
            if (k == 7) locked = 1'b1;
        end

        // Lock loss in RUN.
        locked = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check("loss_cpu_rst_n", {7'd0, cpu_rst_n}, {7'd0, (k < 3)});
            check("loss_pll_rst", {7'd0, pll_rst}, {7'd0, (k >= 3 && k <= 6)});
            check("loss_count_first", loss_count, (k >= 3) ? 8'd1 : 8'd0);
        end

        // Repeated losses up to 300 total; the counter must stick at 255.
        for (int i = 2; i <= 300; i++) begin
            locked = 1'b1;
            step(20);
            check("sat_in_run", {7'd0, cpu_rst_n}, 8'd1);
            locked = 1'b0;
            step(4);
            exp_loss = (i > 255) ? 255 : i;
            check("sat_loss_count", loss_count, 8'(exp_loss));
        end

        // Reset while counting in STABLE.
        locked = 1'b1;
        step(8);
        check("stable_pre_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        check("stable_pre_pll_rst", {7'd0, pll_rst}, 8'd0);
        check("stable_pre_loss", loss_count, 8'd255);
        rst_n = 1'b0;
        step(1);
        check("rst_stable_pll_rst", {7'd0, pll_rst}, 8'd1);
        check("rst_stable_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        check("rst_stable_ready", {7'd0, ready}, 8'd0);
        check("rst_stable_loss", loss_count, 8'd0);

        // Reset while in RUN, with a non-zero loss count.
        rst_n = 1'b1;
        step(14);
        check("run_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd1);
        check("run_ready", {7'd0, ready}, 8'd1);
        locked = 1'b0;
        step(4);
        check("run_loss_one", loss_count, 8'd1);
        check("run_loss_pll_rst", {7'd0, pll_rst}, 8'd1);
        locked = 1'b1;
        step(20);
        check("run_again_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd1);
        check("run_again_loss", loss_count, 8'd1);
        rst_n = 1'b0;
        step(1);
        check("rst_run_pll_rst", {7'd0, pll_rst}, 8'd1);
        check("rst_run_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);
        check("rst_run_ready", {7'd0, ready}, 8'd0);
        check("rst_run_loss", loss_count, 8'd0);

        // Lock never arrives: re-pulse every 36 cycles with the timeout, else wait forever.
        locked = 1'b0;
        rst_n  = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            step(1);
`ifdef PLL_SEQ_TIMEOUT_EN
            check("timeout_pll_rst", {7'd0, pll_rst},
                  {7'd0, (k < P_RST) || (((k - P_RST) % (P_RST + P_TO)) >= P_TO)});
`else
            check("no_timeout_pll_rst", {7'd0, pll_rst}, {7'd0, (k < P_RST)});
`endif
        end
        check("timeout_loss_count", loss_count, 8'd0);
        check("timeout_cpu_rst_n", {7'd0, cpu_rst_n}, 8'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
